bram_sd_clear_arbiter: RTL and testbench
========================================

Name: bram_sd_clear_arbiter

Overview:
- Controller placed in front of the 32b x 1024 one-read/one-write BRAM wrapper.
- After reset or flush, it sweeps every entry to a known value, because BRAM contents are not reset.
- It then shares the single read port between two requesters (A, B) using round-robin arbitration.
- It owns the write port, arbitrating between the clear engine and one client writer, and forwards same-cycle write data to the read response so read-during-write to the same address returns the new value.
- Used by predictor/tag-array style structures in the core that need a clean table after flush.

Parameters:
- AW, 10, address width; depth = 2**AW.
- DW, 32, data width.
- CLR_VALUE, 0, value written to every entry during clear.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous reset, active low.
- flush  in  1  request a full re-clear.
- ready  out  1  table usable; high only in RUN.
- rd_req_a  in  1  requester A read request.
- rd_addr_a  in  AW  requester A address.
- rd_gnt_a  out  1  combinational grant to A.
- rsp_valid_a  out  1  A read data valid, one cycle after grant.
- rd_req_b  in  1  requester B read request.
- rd_addr_b  in  AW  requester B address.
- rd_gnt_b  out  1  combinational grant to B.
- rsp_valid_b  out  1  B read data valid, one cycle after grant.
- rsp_data  out  DW  read data for whichever rsp_valid_* is high.
- wr_en  in  1  client write.
- wr_addr  in  AW  client write address.
- wr_data  in  DW  client write data.
- bram_raddr  out  AW  to BRAM read address.
- bram_rden  out  1  to BRAM read enable.
- bram_rdata  in  DW  from BRAM; valid the cycle after bram_rden.
- bram_waddr  out  AW  to BRAM write address.
- bram_wen  out  1  to BRAM write enable.
- bram_wdata  out  DW  to BRAM write data.

Behaviour:

States:
- CLEAR, RUN. Reset (resetn=0, asynchronous) forces CLEAR with clr_cnt=0, last_gnt=B (so A wins the first contention), rsp_valid_a=rsp_valid_b=0, ready=0, and the bypass register cleared.

CLEAR:
- Each cycle drives bram_wen=1, bram_waddr=clr_cnt, bram_wdata=CLR_VALUE, then clr_cnt++.
- When the write at clr_cnt=2**AW-1 completes, the next state is RUN. A clear therefore takes exactly 2**AW cycles, and ready rises on the first cycle after the last clear write.
- Client wr_en is ignored (dropped). No grants are issued and bram_rden=0.
- flush in CLEAR restarts clr_cnt at 0 on the next cycle.

RUN:
- ready=1.
- flush=1 moves to CLEAR next cycle with clr_cnt=0.
- In the flush cycle itself, grants and writes are still serviced normally.

Write path (RUN):
- bram_wen=wr_en, bram_waddr=wr_addr, bram_wdata=wr_data, passed through combinationally.

Read arbitration (RUN only):
- Only A requesting: gnt_a=1. Only B requesting: gnt_b=1.
- Both requesting: grant goes to the requester not equal to last_gnt.
- last_gnt updates to the granted requester on every grant.
- At most one grant per cycle. A requester not granted must hold its request; the block keeps no request state.
- bram_rden = gnt_a|gnt_b; bram_raddr = address of the granted requester.

Response:
- rsp_valid_x is registered, equal to gnt_x from the previous cycle.
- rsp_data = byp_hit ? byp_data : bram_rdata.
- byp_hit and byp_data are registered in the grant cycle: byp_hit = wr_en && wr_addr == granted address; byp_data = wr_data.
- Net effect: write-first semantics for same-cycle read/write.
- A write in the response cycle does not affect that response.
- rsp_data is don't-care when neither valid is high; the bench must not check it.

Reset mid-operation:
- Any in-flight response is discarded; both rsp_valid_* drop to 0 immediately on resetn low.

Test Plan:
1. Reset release, no requests -> ready=0 for 1024 cycles; bram_waddr sweeps 0..1023 with bram_wdata=0; ready=1 on cycle 1025; then read of addr 0x3FF returns 0x00000000 with rsp_valid_a one cycle after gnt_a.
2. RUN: write 0xDEADBEEF to 0x010; next cycle A reads 0x010 -> gnt_a same cycle, rsp_valid_a next cycle, rsp_data=0xDEADBEEF.
3. Same cycle: wr_en addr 0x020 data 0x12345678, and B reads 0x020 -> rsp_data=0x12345678 (bypass). Repeat with read address 0x021 -> old stored value.
4. A and B both request continuously for 4 cycles -> grants A,B,A,B; rsp_valid_a/b alternate one cycle later with the correct per-address data.
5. flush mid-RUN, then flush again after 500 CLEAR cycles -> clr_cnt restarts at 0; ready stays low for 500+1024 cycles total; wr_en during CLEAR is not written (entry reads CLR_VALUE afterwards).
6. resetn asserted low while rsp_valid_b=1 and mid-CLEAR -> outputs zero immediately (asynchronous); after release a full 1024-cycle clear reoccurs.

Source files
------------

// File: rtl/bram_sd_clear_arbiter.sv
// Front-end for a 1R/1W BRAM: sweeps the table to CLR_VALUE after reset/flush, then
// round-robins the read port between A and B with write-first forwarding on collisions.
//
// state    | meaning
// ST_CLEAR | writing CLR_VALUE to entry clr_cnt each cycle; no reads, client writes dropped
// ST_RUN   | table valid; reads arbitrated, client writes passed through
module bram_sd_clear_arbiter #(
    parameter int              AW        = 10,
    parameter int              DW        = 32,
    parameter logic [DW-1:0]   CLR_VALUE = '0
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush,
    output logic          ready,
    input  logic          rd_req_a,
    input  logic [AW-1:0] rd_addr_a,
    output logic          rd_gnt_a,
    output logic          rsp_valid_a,
    input  logic          rd_req_b,
    input  logic [AW-1:0] rd_addr_b,
    output logic          rd_gnt_b,
    output logic          rsp_valid_b,
    output logic [DW-1:0] rsp_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic [AW-1:0] bram_raddr,
    output logic          bram_rden,
    input  logic [DW-1:0] bram_rdata,
    output logic [AW-1:0] bram_waddr,
    output logic          bram_wen,
    output logic [DW-1:0] bram_wdata
);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic          last_gnt_b_q, last_gnt_b_d;
    logic          ready_q, ready_d;
    logic          rsp_valid_a_q, rsp_valid_a_d;
    logic          rsp_valid_b_q, rsp_valid_b_d;
    logic          byp_hit_q, byp_hit_d;
    logic [DW-1:0] byp_data_q, byp_data_d;

    logic          in_run;
    logic          gnt_a, gnt_b;

    always_comb begin
        in_run = (state_q == ST_RUN);
        // On contention the requester that did not win last time gets the port.
        gnt_a  = in_run && rd_req_a && (!rd_req_b || last_gnt_b_q);
        gnt_b  = in_run && rd_req_b && (!rd_req_a || !last_gnt_b_q);

        rd_gnt_a   = gnt_a;
        rd_gnt_b   = gnt_b;
        bram_rden  = gnt_a | gnt_b;
        bram_raddr = gnt_b ? rd_addr_b : rd_addr_a;

        if (in_run) begin
            bram_wen   = wr_en;
            bram_waddr = wr_addr;
            bram_wdata = wr_data;
        end else begin
            bram_wen   = 1'b1;
            bram_waddr = clr_cnt_q;
            bram_wdata = CLR_VALUE;
        end

        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (!in_run) begin
            if (flush) begin
                clr_cnt_d = '0;
            end else begin
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == '1) begin
                    state_d = ST_RUN;
                end
            end
        end else if (flush) begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
        end

        ready_d       = (state_d == ST_RUN);
        last_gnt_b_d  = gnt_b ? 1'b1 : (gnt_a ? 1'b0 : last_gnt_b_q);
        rsp_valid_a_d = gnt_a;
        rsp_valid_b_d = gnt_b;
        // The BRAM returns the pre-write word on a same-address collision, so capture the new one.
        byp_hit_d     = bram_rden && wr_en && (wr_addr == bram_raddr);
        byp_data_d    = wr_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_CLEAR;
            clr_cnt_q     <= '0;
            last_gnt_b_q  <= 1'b1;
            ready_q       <= 1'b0;
            rsp_valid_a_q <= 1'b0;
            rsp_valid_b_q <= 1'b0;
            byp_hit_q     <= 1'b0;
            byp_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            last_gnt_b_q  <= last_gnt_b_d;
            ready_q       <= ready_d;
            rsp_valid_a_q <= rsp_valid_a_d;
            rsp_valid_b_q <= rsp_valid_b_d;
            byp_hit_q     <= byp_hit_d;
            byp_data_q    <= byp_data_d;
        end
    end

    assign ready       = ready_q;
    assign rsp_valid_a = rsp_valid_a_q;
    assign rsp_valid_b = rsp_valid_b_q;
    assign rsp_data    = byp_hit_q ? byp_data_q : bram_rdata;

endmodule

// File: tb/tb_bram_sd_clear_arbiter.sv
// Bench for bram_sd_clear_arbiter: read-first BRAM model plus a table/round-robin
// reference model checked every cycle, with directed and random scenarios.
module tb_bram_sd_clear_arbiter;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        ready;
    logic        rd_req_a, rd_req_b;
    logic [9:0]  rd_addr_a, rd_addr_b;
    logic        rd_gnt_a, rd_gnt_b;
    logic        rsp_valid_a, rsp_valid_b;
    logic [31:0] rsp_data;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic [9:0]  bram_raddr, bram_waddr;
    logic        bram_rden, bram_wen;
    logic [31:0] bram_rdata, bram_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    bram_sd_clear_arbiter dut (
        .clk(clk), .resetn(resetn), .flush(flush), .ready(ready),
        .rd_req_a(rd_req_a), .rd_addr_a(rd_addr_a), .rd_gnt_a(rd_gnt_a), .rsp_valid_a(rsp_valid_a),
        .rd_req_b(rd_req_b), .rd_addr_b(rd_addr_b), .rd_gnt_b(rd_gnt_b), .rsp_valid_b(rsp_valid_b),
        .rsp_data(rsp_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .bram_raddr(bram_raddr), .bram_rden(bram_rden), .bram_rdata(bram_rdata),
        .bram_waddr(bram_waddr), .bram_wen(bram_wen), .bram_wdata(bram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: registered read returning the pre-write contents on a collision.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (bram_wen)  mem[bram_waddr] <= bram_wdata;
        if (bram_rden) bram_rdata      <= mem[bram_raddr];
    end

    // Reference model: visible table contents, clear cycles left, last winner, pending response.
    logic [31:0] ref_tab [0:1023];
    int          clr_left;
    logic        last_b;
    logic        pend_a, pend_b;
    logic [31:0] pend_data;

    task automatic model_reset();
        clr_left = 1024;
        last_b   = 1'b1;
        pend_a   = 1'b0;
        pend_b   = 1'b0;
    endtask

    task automatic set_idle();
        flush = 0; rd_req_a = 0; rd_req_b = 0; wr_en = 0;
        rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; wr_data = '0;
    endtask

    // One clock: inputs already driven just after a falling edge; check, advance model, wait.
    task automatic tick();
        logic        ea, eb, exp_ready;
        logic [9:0]  ga, exp_waddr;
        #1;
        exp_ready = (clr_left == 0);
        ea = 1'b0;
        eb = 1'b0;
        if (exp_ready) begin
            if (rd_req_a && rd_req_b) begin
                ea = last_b;
                eb = !last_b;
            end else begin
                ea = rd_req_a;
                eb = rd_req_b;
            end
        end
        ga = eb ? rd_addr_b : rd_addr_a;

        n_tests++;
        if (ready !== exp_ready) begin
            n_fail++; $display("FAIL ready: got %b want %b t=%0t", ready, exp_ready, $time);
        end
        n_tests++;
        if ({rd_gnt_a, rd_gnt_b} !== {ea, eb}) begin
            n_fail++; $display("FAIL grant: got a=%b b=%b want a=%b b=%b t=%0t", rd_gnt_a, rd_gnt_b, ea, eb, $time);
        end
        n_tests++;
        if ({rsp_valid_a, rsp_valid_b} !== {pend_a, pend_b}) begin
            n_fail++; $display("FAIL rsp_valid: got a=%b b=%b want a=%b b=%b t=%0t", rsp_valid_a, rsp_valid_b, pend_a, pend_b, $time);
        end
        if (pend_a || pend_b) begin
            n_tests++;
            if (rsp_data !== pend_data) begin
                n_fail++; $display("FAIL rsp_data: got %h want %h t=%0t", rsp_data, pend_data, $time);
            end
        end
        n_tests++;
        if (bram_rden !== (ea | eb)) begin
            n_fail++; $display("FAIL bram_rden: got %b want %b t=%0t", bram_rden, ea | eb, $time);
        end
        if (ea || eb) begin
            n_tests++;
            if (bram_raddr !== ga) begin
                n_fail++; $display("FAIL bram_raddr: got %h want %h t=%0t", bram_raddr, ga, $time);
            end
        end
        if (!exp_ready) begin
            exp_waddr = 10'(1024 - clr_left);
            n_tests++;
            if (bram_wen !== 1'b1 || bram_waddr !== exp_waddr || bram_wdata !== 32'h0) begin
                n_fail++; $display("FAIL clear_write: got wen=%b addr=%h data=%h want 1 %h 0 t=%0t", bram_wen, bram_waddr, bram_wdata, exp_waddr, $time);
            end
        end else begin
            n_tests++;
            if (bram_wen !== wr_en) begin
                n_fail++; $display("FAIL bram_wen: got %b want %b t=%0t", bram_wen, wr_en, $time);
            end
            if (wr_en) begin
                n_tests++;
                if (bram_waddr !== wr_addr || bram_wdata !== wr_data) begin
                    n_fail++; $display("FAIL client_write: got %h/%h want %h/%h t=%0t", bram_waddr, bram_wdata, wr_addr, wr_data, $time);
                end
            end
        end

        pend_a = ea;
        pend_b = eb;
        if (ea || eb) begin
            pend_data = (wr_en && wr_addr == ga) ? wr_data : ref_tab[ga];
            last_b    = eb;
        end
        if (exp_ready) begin
            if (wr_en) ref_tab[wr_addr] = wr_data;
            if (flush) clr_left = 1024;
        end else if (flush) begin
            clr_left = 1024;
        end else begin
            clr_left--;
            if (clr_left == 0) begin
                for (int i = 0; i < 1024; i++) ref_tab[i] = 32'h0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 0;
        set_idle();
        rd_req_a = 1; rd_req_b = 1;
        model_reset();
        #1;
        n_tests++;
        if (ready !== 1'b0 || rsp_valid_a !== 1'b0 || rsp_valid_b !== 1'b0 || rd_gnt_a !== 1'b0 || rd_gnt_b !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: got rdy=%b va=%b vb=%b ga=%b gb=%b want all 0", ready, rsp_valid_a, rsp_valid_b, rd_gnt_a, rd_gnt_b);
        end
        set_idle();
        @(negedge clk);
        resetn = 1;
        for (int i = 0; i < 1024; i++) tick();
        n_tests++;
        if (ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_after_clear: got %b want 1", ready);
        end
        rd_req_a = 1; rd_addr_a = 10'h3FF;
        tick();
        set_idle();
        n_tests++;
        if (rsp_valid_a !== 1'b1 || rsp_data !== 32'h0) begin
            n_fail++; $display("FAIL read_3ff: got v=%b d=%h want 1 00000000", rsp_valid_a, rsp_data);
        end
        tick();
    endtask

    task automatic test_write_read();
        wr_en = 1; wr_addr = 10'h010; wr_data = 32'hDEADBEEF;
        tick();
        set_idle();
        rd_req_a = 1; rd_addr_a = 10'h010;
        tick();
        set_idle();
        n_tests++;
        if (rsp_valid_a !== 1'b1 || rsp_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL write_then_read: got v=%b d=%h want 1 deadbeef", rsp_valid_a, rsp_data);
        end
        tick();
    endtask

    task automatic test_bypass();
        wr_en = 1; wr_addr = 10'h021; wr_data = 32'hCAFE0021;
        tick();
        set_idle();
        wr_en = 1; wr_addr = 10'h020; wr_data = 32'h12345678;
        rd_req_b = 1; rd_addr_b = 10'h020;
        tick();
        n_tests++;
        if (rsp_valid_b !== 1'b1 || rsp_data !== 32'h12345678) begin
            n_fail++; $display("FAIL bypass_hit: got v=%b d=%h want 1 12345678", rsp_valid_b, rsp_data);
        end
        wr_en = 1; wr_addr = 10'h020; wr_data = 32'h87654321;
        rd_req_b = 1; rd_addr_b = 10'h021;
        tick();
        set_idle();
        n_tests++;
        if (rsp_valid_b !== 1'b1 || rsp_data !== 32'hCAFE0021) begin
            n_fail++; $display("FAIL bypass_miss: got v=%b d=%h want 1 cafe0021", rsp_valid_b, rsp_data);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        wr_en = 1; wr_addr = 10'h040; wr_data = 32'h11110040;
        tick();
        wr_addr = 10'h041; wr_data = 32'h22220041;
        tick();
        set_idle();
        rd_req_a = 1; rd_addr_a = 10'h040;
        rd_req_b = 1; rd_addr_b = 10'h041;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (rsp_valid_a !== (i % 2 == 0) || rsp_valid_b !== (i % 2 == 1) ||
                rsp_data !== ((i % 2 == 0) ? 32'h11110040 : 32'h22220041)) begin
                n_fail++; $display("FAIL alternate[%0d]: got va=%b vb=%b d=%h", i, rsp_valid_a, rsp_valid_b, rsp_data);
            end
        end
        set_idle();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rd_req_a  = 1'($urandom_range(1));
            rd_req_b  = 1'($urandom_range(1));
            rd_addr_a = 10'($urandom_range(15));
            rd_addr_b = 10'($urandom_range(15));
            wr_en     = 1'($urandom_range(1));
            wr_addr   = 10'($urandom_range(15));
            wr_data   = $urandom;
            tick();
        end
        set_idle();
        tick();
    endtask

    task automatic test_flush();
        int cnt;
        wr_en = 1; wr_addr = 10'h030; wr_data = 32'hBADC0FFE;
        tick();
        set_idle();
        flush = 1; rd_req_a = 1; rd_addr_a = 10'h010;
        tick();
        set_idle();
        cnt = 0;
        while (ready === 1'b0 && cnt < 3000) begin
            flush    = (cnt == 499);
            rd_req_b = 1;
            wr_en    = (cnt == 1200);
            wr_addr  = 10'h030;
            wr_data  = 32'hFFFF0000;
            tick();
            cnt++;
        end
        set_idle();
        n_tests++;
        if (cnt !== 1524) begin
            n_fail++; $display("FAIL flush_clear_len: got %0d cycles want 1524", cnt);
        end
        rd_req_a = 1; rd_addr_a = 10'h030;
        tick();
        set_idle();
        n_tests++;
        if (rsp_valid_a !== 1'b1 || rsp_data !== 32'h0) begin
            n_fail++; $display("FAIL dropped_write: got v=%b d=%h want 1 00000000", rsp_valid_a, rsp_data);
        end
        tick();
    endtask

    task automatic test_async_reset();
        int cnt;
        flush = 1; rd_req_b = 1; rd_addr_b = 10'h041;
        tick();
        set_idle();
        n_tests++;
        if (rsp_valid_b !== 1'b1 || ready !== 1'b0) begin
            n_fail++; $display("FAIL pre_reset: got vb=%b rdy=%b want 1 0", rsp_valid_b, ready);
        end
        #2 resetn = 0;
        #1;
        n_tests++;
        if (rsp_valid_b !== 1'b0 || rsp_valid_a !== 1'b0 || ready !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got vb=%b va=%b rdy=%b want 0 0 0", rsp_valid_b, rsp_valid_a, ready);
        end
        model_reset();
        @(negedge clk);
        resetn = 1;
        cnt = 0;
        while (ready === 1'b0 && cnt < 2000) begin
            tick();
            cnt++;
        end
        n_tests++;
        if (cnt !== 1024) begin
            n_fail++; $display("FAIL reclear_len: got %0d cycles want 1024", cnt);
        end
        rd_req_a = 1; rd_addr_a = 10'h010;
        tick();
        set_idle();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = $urandom;
            ref_tab[i] = 32'h0;
        end
        pend_data = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_back_to_back();
        test_random();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
